// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one single-port memory between the fetch and memory stages.
// One access is in flight at a time. The access runs from the issue cycle to the
// ack cycle inclusive, so at least one IDLE cycle separates consecutive accesses.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [DATA_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_F,
    output logic              stall_M
);

    typedef enum logic [1:0] {IDLE, IF_ACC, D_ACC} state_t;

    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    state_t     state, state_nxt;
    logic [2:0] cnt;
    logic       last_d;     // 1: data was granted last, 0: fetch was granted last
    logic       if_elig, d_elig;

    // A request is only eligible while its ack is low, so a request still held
    // during its own ack cycle is not granted a second time.
    assign if_elig = if_req & ~if_ack;
    assign d_elig  = d_req & ~d_ack;

    assign stall_F = if_req & ~if_ack;
    assign stall_M = d_req & ~d_ack;

    // Next-state: round-robin grant out of IDLE, leave ACC in the ack cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (if_elig && d_elig) state_nxt = last_d ? IF_ACC : D_ACC;
                else if (if_elig)      state_nxt = IF_ACC;
                else if (d_elig)       state_nxt = D_ACC;
            end
            IF_ACC:  if (if_ack) state_nxt = IDLE;
            D_ACC:   if (d_ack)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Issue command on entry to ACC, count down the latency, then capture data and ack
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            last_d    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            mem_en <= 1'b0;
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            if (state == IDLE && state_nxt == IF_ACC) begin
                mem_en   <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= if_addr;
                cnt      <= LAT;
            end else if (state == IDLE && state_nxt == D_ACC) begin
                mem_en    <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                cnt       <= LAT;
            end else if (state != IDLE) begin
                if (cnt != 3'd0) begin
                    cnt <= cnt - 3'd1;
                end else if (!if_ack && !d_ack) begin
                    // mem_rdata is valid this cycle; mem_we still holds the issued op
                    if (state == IF_ACC) begin
                        if_ack   <= 1'b1;
                        if_rdata <= mem_rdata;
                        last_d   <= 1'b0;
                    end else begin
                        d_ack  <= 1'b1;
                        if (!mem_we) d_rdata <= mem_rdata;
                        last_d <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, all
// checked against a transaction-level schedule model.
module tb_mem_port_arbiter;
    localparam int L = 2;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [W-1:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [W-1:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic         if_ack, d_ack, mem_en, mem_we, stall_F, stall_M;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(L), .DATA_W(W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_F(stall_F), .stall_M(stall_M)
    );

    int n_chk = 0, n_pass = 0;
    int t = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle=%0d got=%h exp=%h", tag, t, got, exp);
    endtask

    // Schedule model: events keyed by cycle number
    int           busy_until = 0;
    bit           lg_d = 1'b0;
    bit           e_en[int], e_we[int], e_ifack[int], e_dack[int], e_dst[int], e_zero[int];
    logic [W-1:0] e_addr[int], e_wd[int], rd_hist[int];
    logic [W-1:0] x_if_rd = '0, x_d_rd = '0;

    // Decide what the arbiter does with the inputs present in cycle t
    task automatic model_cycle();
        bit ei, ed, g;
        if (rst) begin
            for (int k = t + 1; k <= t + L + 3; k++) begin
                e_en.delete(k); e_ifack.delete(k); e_dack.delete(k);
            end
            busy_until = t + 1;
            lg_d       = 1'b0;
            x_if_rd    = '0;
            x_d_rd     = '0;
            e_zero[t+1] = 1'b1;
        end else if (t >= busy_until) begin
            ei = if_req && !e_ifack.exists(t);
            ed = d_req && !e_dack.exists(t);
            if (ei || ed) begin
                g = (ei && ed) ? !lg_d : ed;
                e_en[t+1]   = 1'b1;
                e_we[t+1]   = g ? d_we : 1'b0;
                e_addr[t+1] = g ? d_addr : if_addr;
                e_wd[t+1]   = d_wdata;
                if (g) begin
                    e_dack[t+L+2] = 1'b1;
                    e_dst[t+L+2]  = d_we;
                end else begin
                    e_ifack[t+L+2] = 1'b1;
                end
                busy_until = t + L + 3;
                lg_d       = g;
            end
        end
    endtask

    task automatic check_reg();
        bit en;
        en = e_en.exists(t);
        check("mem_en", mem_en, en);
        if (en) begin
            check("mem_addr", mem_addr, e_addr[t]);
            check("mem_we", mem_we, e_we[t]);
            if (e_we[t]) check("mem_wdata", mem_wdata, e_wd[t]);
        end
        if (e_zero.exists(t)) begin
            check("rst_addr", mem_addr, '0);
            check("rst_we", mem_we, '0);
            check("rst_wdata", mem_wdata, '0);
        end
        if (e_ifack.exists(t)) x_if_rd = rd_hist[t-1];
        if (e_dack.exists(t) && !e_dst[t]) x_d_rd = rd_hist[t-1];
        check("if_ack", if_ack, e_ifack.exists(t));
        check("d_ack", d_ack, e_dack.exists(t));
        check("if_rdata", if_rdata, x_if_rd);
        check("d_rdata", d_rdata, x_d_rd);
    endtask

    // One clock: settle inputs, check stalls, run model, clock, check registers
    task automatic step();
        #1;
        check("stall_F", stall_F, if_req && !e_ifack.exists(t));
        check("stall_M", stall_M, d_req && !e_dack.exists(t));
        model_cycle();
        @(posedge clk);
        #1;
        t++;
        check_reg();
    endtask

    task automatic drv_rd();
        mem_rdata  = $urandom;
        rd_hist[t] = mem_rdata;
    endtask

    task automatic do_reset();
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        drv_rd(); step();
        drv_rd(); step();
        rst = 1'b0;
    endtask

    int  base, c, nack, ack_c, en_cnt, prev_src, src;
    int  req_start[2];
    bit  if_pend = 1'b0, d_pend = 1'b0;
    logic [W-1:0] d_hold;

    initial begin
        @(posedge clk); #1;
        // Reset and quiet outputs
        do_reset();

        // Single fetch
        base = t - 1;
        if_req = 1'b1; if_addr = 32'h10;
        for (int i = 0; i < 7; i++) begin
            c = t - base;
            if (e_ifack.exists(t)) if_req = 1'b0;
            mem_rdata = (c == 4) ? 32'hDEADBEEF : $urandom;
            rd_hist[t] = mem_rdata;
            #1;
            if (c <= 4) check("F_stall", stall_F, 1'b1);
            step();
            c = t - base;
            if (c == 2) begin check("F_en", mem_en, 1'b1); check("F_addr", mem_addr, 32'h10); end
            if (c == 5) begin check("F_ack", if_ack, 1'b1); check("F_rdata", if_rdata, 32'hDEADBEEF); end
        end

        // Tie after reset: data first, then fetch
        do_reset();
        base = t - 1;
        if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        for (int i = 0; i < 11; i++) begin
            if (e_ifack.exists(t)) if_req = 1'b0;
            if (e_dack.exists(t)) d_req = 1'b0;
            drv_rd(); step();
            c = t - base;
            if (c == 2)  begin check("T_en2", mem_en, 1'b1); check("T_addr2", mem_addr, 32'h200); end
            if (c == 5)  check("T_dack", d_ack, 1'b1);
            if (c == 7)  begin check("T_en7", mem_en, 1'b1); check("T_addr7", mem_addr, 32'h100); end
            if (c == 10) check("T_iack", if_ack, 1'b1);
        end

        // Store leaves d_rdata alone
        d_hold = x_d_rd;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h55;
        en_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (e_dack.exists(t)) d_req = 1'b0;
            drv_rd(); step();
            if (mem_en) begin
                en_cnt++;
                check("S_we", mem_we, 1'b1);
                check("S_addr", mem_addr, 32'h40);
                check("S_wdata", mem_wdata, 32'h55);
            end
        end
        check("S_en_cnt", en_cnt, 1);
        check("S_rdata", d_rdata, d_hold);
        d_we = 1'b0;

        // Reset in A+1 of a fetch abandons it; next fetch has uncontended latency
        do_reset();
        base = t - 1;
        nack = 0; ack_c = -1;
        if_addr = 32'h300;
        for (int i = 0; i < 14; i++) begin
            c = t - base;
            rst = (c == 3);
            if_req = (c <= 3) || (c >= 9 && ack_c < 0);
            drv_rd(); step();
            c = t - base;
            if (if_ack && c < 9) nack++;
            if (if_ack && c >= 9 && ack_c < 0) ack_c = c;
        end
        rst = 1'b0;
        check("R_noack", nack, 0);
        check("R_lat", ack_c - 9, L + 2);

        // Continuous contention: strict alternation and bounded wait
        do_reset();
        prev_src = -1;
        if_req = 1'b1; d_req = 1'b1;
        if_addr = $urandom & 32'h7FFF_FFFF; d_addr = $urandom | 32'h8000_0000;
        d_we = 1'($urandom); d_wdata = $urandom;
        req_start[0] = t; req_start[1] = t;
        for (int i = 0; i < 40; i++) begin
            if (e_ifack.exists(t)) begin if_addr = $urandom & 32'h7FFF_FFFF; req_start[0] = t; end
            if (e_dack.exists(t)) begin
                d_addr = $urandom | 32'h8000_0000; d_we = 1'($urandom); d_wdata = $urandom;
                req_start[1] = t;
            end
            drv_rd(); step();
            if (if_ack || d_ack) check("C_dup", mem_en, 1'b0);
            if (mem_en) begin
                src = int'(mem_addr[W-1]);
                if (prev_src >= 0) check("C_alt", src, 1 - prev_src);
                check("C_wait", (t - req_start[src]) <= 2 * (L + 2), 1'b1);
                prev_src = src;
            end
        end

        // Random traffic with occasional resets
        if_req = 1'b0; d_req = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (if_pend && e_ifack.exists(t)) if_pend = 1'b0;
            if (d_pend && e_dack.exists(t)) d_pend = 1'b0;
            if (!if_pend && $urandom_range(2) == 0) begin
                if_pend = 1'b1; if_addr = $urandom;
            end
            if (!d_pend && $urandom_range(2) == 0) begin
                d_pend = 1'b1; d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom);
            end
            if_req = if_pend;
            d_req  = d_pend;
            rst    = ($urandom_range(149) == 0);
            drv_rd(); step();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
